keypad_scanner: RTL and testbench

Input-side counterpart to the multiplexed hex display driver: time-multiplexes a 4x4 matrix keypad by driving one column at a time, reading the four rows, debouncing whole scan frames and reporting new key presses as 4-bit hex codes. The codes match the display driver's nibble convention, so a received code can be written straight into a display digit. It sits between the board keypad pins and the user logic, with a valid/ack handshake toward the consumer.

---
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with whole-frame debounce and valid/ack key events.
// Optional auto-repeat of the lowest held key is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
    parameter int SCAN_DIV      = 5000,
    parameter int DEBOUNCE      = 2,
    parameter int REPEAT_FRAMES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic [15:0] keys,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ack,
    output logic        overflow
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE);

    if (SCAN_DIV < 1 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_FRAMES < 1) begin : g_bad_cfg
        $error("keypad_scanner: unsupported parameter set");
    end

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        lowest_idx = 4'd0;
        for (int n = 15; n >= 0; n--) begin
            if (v[n]) lowest_idx = 4'(n);
        end
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        sat_inc = (v >= DB) ? DB : v + 4'd1;
    endfunction

    logic [3:0]       rows_s1_q, rows_s1_d, rows_s2_q, rows_s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;
    logic [15:0]      snap_q, snap_d, prev_q, prev_d, keys_q, keys_d;
    logic [3:0]       stable_q, stable_d;
    logic             evt_q, evt_d;
    logic [3:0]       evt_idx_q, evt_idx_d, code_q, code_d;
    logic             valid_q, valid_d, ovf_q, ovf_d;
    logic             tick, commit;
    logic [15:0]      frame;
`ifdef KEYPAD_REPEAT_EN
    localparam int RF_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REPEAT_FRAMES - 1);
    logic [RF_W-1:0] rep_q, rep_d;
`endif

    always_comb begin
        rows_s1_d = rows;
        rows_s2_d = rows_s1_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        snap_d    = snap_q;
        prev_d    = prev_q;
        keys_d    = keys_q;
        stable_d  = stable_q;
        evt_d     = 1'b0;
        evt_idx_d = evt_idx_q;
        code_d    = code_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        commit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d     = rep_q;
`endif
        tick  = (cnt_q == CNT_LAST);
        frame = snap_q;
        frame[{col_q, 2'b00} +: 4] = ~rows_s2_q;

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
            col_d  = col_q + 2'd1;
            snap_d = frame;
            // Last column of the frame: debounce the whole 16-key snapshot at once.
            if (col_q == 2'd3) begin
                if (frame != prev_q) begin
                    prev_d   = frame;
                    stable_d = 4'd0;
                end else begin
                    stable_d = sat_inc(stable_q);
                    commit   = (stable_d == DB);
                end
                if (commit) begin
                    keys_d = frame;
                    if ((frame & ~keys_q) != 16'd0) begin
                        evt_d     = 1'b1;
                        evt_idx_d = lowest_idx(frame & ~keys_q);
                    end
                end
`ifdef KEYPAD_REPEAT_EN
                if (commit && (frame != keys_q)) begin
                    rep_d = '0;
                end else if (keys_q != 16'd0) begin
                    if (rep_q == RF_LAST) begin
                        rep_d     = '0;
                        evt_d     = 1'b1;
                        evt_idx_d = lowest_idx(keys_q);
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end else begin
                    rep_d = '0;
                end
`endif
            end
        end

        // Events are presented one clock after the commit, so keys is already settled.
        if (evt_q) begin
            if (!valid_q || key_ack) begin
                code_d  = evt_idx_q;
                valid_d = 1'b1;
                if (key_ack) ovf_d = 1'b0;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (key_ack && valid_q) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_s1_q <= 4'hF;
            rows_s2_q <= 4'hF;
            cnt_q     <= '0;
            col_q     <= 2'd0;
            snap_q    <= 16'd0;
            prev_q    <= 16'd0;
            keys_q    <= 16'd0;
            stable_q  <= 4'd0;
            evt_q     <= 1'b0;
            evt_idx_q <= 4'd0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            rows_s1_q <= rows_s1_d;
            rows_s2_q <= rows_s2_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            snap_q    <= snap_d;
            prev_q    <= prev_d;
            keys_q    <= keys_d;
            stable_q  <= stable_d;
            evt_q     <= evt_d;
            evt_idx_q <= evt_idx_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign cols      = ~(4'b0001 << col_q);
    assign keys      = keys_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: frame-level reference model plus directed key scenarios.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 2;
    localparam int RF = 3;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rows, cols, key_code;
    logic [15:0] keys;
    logic        key_valid, overflow;
    logic        key_ack = 1'b0;
    logic [15:0] pressed = 16'd0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_FRAMES(RF)) dut (
        .clk(clk), .rst(rst), .rows(rows), .cols(cols), .keys(keys),
        .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack), .overflow(overflow)
    );

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!cols[c])
                for (int r = 0; r < 4; r++)
                    if (pressed[c*4 + r]) rows[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int n = 0; n < 16; n++) if (v[n]) return n;
        return 0;
    endfunction

    // Reference model: cycle count since reset, frame-level debounce, event handshake.
    int          m_k, m_stable, m_rep, m_ev_idx;
    logic [15:0] m_prev, m_keys;
    logic        m_ev, m_valid, m_ovf;
    logic [3:0]  m_code;

    always @(posedge clk or posedge rst) begin : model
        logic [15:0] f;
        logic        committed, changed;
        if (rst) begin
            m_k = 0; m_stable = 0; m_rep = 0; m_ev_idx = 0;
            m_prev = 0; m_keys = 0; m_ev = 0; m_valid = 0; m_ovf = 0; m_code = 0;
        end else begin
            if (m_ev) begin
                if (!m_valid || key_ack) begin
                    m_code = 4'(m_ev_idx); m_valid = 1; if (key_ack) m_ovf = 0;
                end else m_ovf = 1;
            end else if (key_ack && m_valid) begin
                m_valid = 0; m_ovf = 0;
            end
            m_ev = 0;
            if (m_k % FR == FR - 1) begin
                f = pressed;
                committed = 0;
                if (f != m_prev) begin
                    m_prev = f; m_stable = 0;
                end else begin
                    if (m_stable < DB) m_stable++;
                    committed = (m_stable == DB);
                end
                changed = committed && (f != m_keys);
                if (committed) begin
                    if ((f & ~m_keys) != 0) begin m_ev = 1; m_ev_idx = lowest(f & ~m_keys); end
                    m_keys = f;
                end
`ifdef KEYPAD_REPEAT_EN
                if (changed || m_keys == 0) m_rep = 0;
                else begin
                    m_rep++;
                    if (m_rep == RF) begin m_rep = 0; m_ev = 1; m_ev_idx = lowest(m_keys); end
                end
`endif
            end
            m_k++;
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] ec;
        ec = ~(4'b0001 << ((m_k / SD) % 4));
        chk("cols", 32'(cols), 32'(ec));
        chk("keys", 32'(keys), 32'(m_keys));
        chk("key_valid", 32'(key_valid), 32'(m_valid));
        chk("key_code", 32'(key_code), 32'(m_code));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    end

    task automatic to_frame_start();
        for (int n = 0; n < FR && (m_k % FR) != 0; n++) @(negedge clk);
    endtask

    task automatic commit_set(input logic [15:0] v);
        to_frame_start();
        pressed = v;
        repeat (3 * FR) @(negedge clk);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic count_events(input int cycles, output int n);
        logic pv;
        n = 0;
        pv = key_valid;
        repeat (cycles) begin
            @(negedge clk);
            if (key_valid && !pv) n++;
            pv = key_valid;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] ctab [4];
        int nev, t_prev;
        ctab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        repeat (3) @(negedge clk);
        chk("rst_cols", 32'(cols), 'b1110);
        chk("rst_keys", 32'(keys), 0);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        for (int j = 0; j < 2 * FR; j++) begin
            chk("cols_seq", 32'(cols), 32'(ctab[(j / SD) % 4]));
            @(negedge clk);
        end

        commit_set(16'h0200);
        chk("k9_keys", 32'(keys), 'h0200);
        chk("k9_valid_early", 32'(key_valid), 0);
        @(negedge clk);
        chk("k9_valid", 32'(key_valid), 1);
        chk("k9_code", 32'(key_code), 9);
        ack_pulse();
        chk("k9_ack", 32'(key_valid), 0);

`ifndef KEYPAD_REPEAT_EN
        count_events(4 * FR, nev);
        chk("k9_single", 32'(nev), 0);
        commit_set(16'h0000);
        chk("rel_keys", 32'(keys), 0);
        for (int f = 0; f < 6; f++) begin
            to_frame_start();
            pressed = (f % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (FR) @(negedge clk);
            chk("bounce_keys", 32'(keys), 0);
            chk("bounce_valid", 32'(key_valid), 0);
        end
        commit_set(16'h0200);
        chk("steady_keys", 32'(keys), 'h0200);
        @(negedge clk);
        chk("steady_valid", 32'(key_valid), 1);
        chk("steady_code", 32'(key_code), 9);
        ack_pulse();
        count_events(3 * FR, nev);
        chk("steady_single", 32'(nev), 0);

        commit_set(16'h0000);
        commit_set(16'h1008);
        chk("two_keys", 32'(keys), 'h1008);
        @(negedge clk);
        chk("two_valid", 32'(key_valid), 1);
        chk("two_code", 32'(key_code), 3);
        ack_pulse();

        commit_set(16'h0000);
        commit_set(16'h0020);
        @(negedge clk);
        chk("k5_code", 32'(key_code), 5);
        commit_set(16'h0060);
        @(negedge clk);
        chk("ovf_code", 32'(key_code), 5);
        chk("ovf_valid", 32'(key_valid), 1);
        chk("ovf_set", 32'(overflow), 1);
        ack_pulse();
        chk("ovf_ack_valid", 32'(key_valid), 0);
        chk("ovf_ack_clr", 32'(overflow), 0);

        commit_set(16'h0000);
        commit_set(16'h0020);
        @(negedge clk);
        commit_set(16'h0060);
        @(negedge clk);
        chk("ovf2_set", 32'(overflow), 1);
        commit_set(16'h0020);
        commit_set(16'h0060);
        ack_pulse();
        chk("ackevt_valid", 32'(key_valid), 1);
        chk("ackevt_code", 32'(key_code), 6);
        chk("ackevt_ovf", 32'(overflow), 0);
        ack_pulse();
        chk("ackevt_done", 32'(key_valid), 0);
`else
        commit_set(16'h0000);
        commit_set(16'h0001);
        @(negedge clk);
        chk("rep_first_valid", 32'(key_valid), 1);
        chk("rep_first_code", 32'(key_code), 0);
        t_prev = m_k;
        ack_pulse();
        for (int e = 0; e < 3; e++) begin
            for (int n = 0; n < 4 * FR && !key_valid; n++) @(negedge clk);
            chk("rep_seen", 32'(key_valid), 1);
            chk("rep_interval", 32'(m_k - t_prev), 32'(3 * FR));
            chk("rep_code", 32'(key_code), 0);
            chk("rep_ovf", 32'(overflow), 0);
            t_prev = m_k;
            ack_pulse();
        end
`endif

        to_frame_start();
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cols", 32'(cols), 'b1110);
        chk("midrst_keys", 32'(keys), 0);
        chk("midrst_code", 32'(key_code), 0);
        chk("midrst_valid", 32'(key_valid), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("restart_cols0", 32'(cols), 'b1110);
        repeat (SD) @(negedge clk);
        chk("restart_cols1", 32'(cols), 'b1101);
        repeat (2 * FR) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
